// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path.
//   rd_state_t  : read-side FSM states
//   data_width  : sample component width from integer/fraction bit counts
//   addr_width  : index width for a frame of nfft samples
//   bitrev      : reverses the low w bits of v
package fft_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic int data_width(input int integer_size, input int fract_size);
    return integer_size + fract_size;
  endfunction

  function automatic int addr_width(input int nfft);
    return $clog2(nfft);
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < w; k++) begin
      r[w-1-k] = v[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port storage for the reorder buffer: one write port, one
// registered read port. Address is {bank, index}; no reset on contents.
//   clk            : clock
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr  : read request, data appears on rd_data after the edge
//   rd_data        : registered read data
module fft_reorder_ram
  import fft_pkg::*;
#(
  parameter int WIDTH   = 36,
  parameter int DEPTH_W = 7
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [DEPTH_W-1:0] rd_addr,
  output logic [WIDTH-1:0]   rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_W];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_reorder_buffer.sv
// Converts bit-reversed FFT output into natural order using two ping-pong
// banks: one bank is filled while the other is streamed out.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_start : input sample strobe, first-sample-of-frame marker
//   in_r/in_i         : bit-reversed-order input samples
//   out_valid         : out_r/out_i carry a natural-order sample
//   out_first/last    : bin 0 / bin NFFT-1 markers
//   frame_drop        : pulse when a partial frame is abandoned by in_start
module fft_reorder_buffer
  import fft_pkg::*;
#(
  parameter  int INTEGER_SIZE = 4,
  parameter  int FRACT_SIZE   = 14,
  parameter  int NFFT         = 64,
  localparam int DATA_WIDTH   = data_width(INTEGER_SIZE, FRACT_SIZE),
  localparam int ADDR_W       = addr_width(NFFT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_start,
  input  logic signed [DATA_WIDTH-1:0] in_r,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  output logic signed [DATA_WIDTH-1:0] out_r,
  output logic signed [DATA_WIDTH-1:0] out_i,
  output logic                         out_valid,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         frame_drop
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NFFT - 1);

  // write side
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d, full_set, full_clr;
  logic              drop_q, drop_d;
  logic              ram_we;
  logic [ADDR_W-1:0] wr_idx;

  // read side
  rd_state_t         state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              other_bank;
  logic              issue;
  logic              iss_bank;
  logic [ADDR_W-1:0] iss_idx;
  logic [2*DATA_WIDTH-1:0] ram_rd_data;

  // pipeline
  logic                         vld_p1_q, first_p1_q, last_p1_q;
  logic signed [DATA_WIDTH-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_first_q, out_first_d;
  logic                         out_last_q, out_last_d;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = '0;
    drop_d    = 1'b0;
    wr_idx    = '0;
    ram_we    = 1'b0;
    if (in_valid && !rst) begin
      ram_we = 1'b1;
      if (in_start) begin
        // A start always begins a fresh frame at index 0; any partially
        // written frame in this bank is simply overwritten.
        wr_idx   = '0;
        wr_cnt_d = ADDR_W'(1);
        drop_d   = (wr_cnt_q != '0);
      end else begin
        wr_idx   = ADDR_W'(bitrev(32'(wr_cnt_q), ADDR_W));
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == LAST_IDX) begin
          full_set[wr_bank_q] = 1'b1;
          wr_bank_d           = ~wr_bank_q;
        end
      end
    end
  end

  assign other_bank = ~rd_bank_q;

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    full_clr  = '0;
    issue     = 1'b0;
    iss_bank  = rd_bank_q;
    iss_idx   = rd_idx_q;
    unique case (state_q)
      IDLE: begin
        // Issue index 0 straight from IDLE so the first sample leaves two
        // edges after the frame completes.
        if (|full_q) begin
          issue     = 1'b1;
          iss_bank  = ~full_q[0];
          iss_idx   = '0;
          state_d   = READ;
          rd_bank_d = ~full_q[0];
          rd_idx_d  = ADDR_W'(1);
        end
      end
      READ: begin
        issue    = 1'b1;
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          full_clr[rd_bank_q] = 1'b1;
          // A bank completing on this very edge counts as full, so the
          // next frame follows with no idle cycle.
          if (full_q[other_bank] || full_set[other_bank]) begin
            rd_bank_d = other_bank;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full_d = (full_q | full_set) & ~full_clr;

  fft_reorder_ram #(
    .WIDTH  (2*DATA_WIDTH),
    .DEPTH_W(ADDR_W + 1)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr({wr_bank_q, wr_idx}),
    .wr_data({in_r, in_i}),
    .rd_en  (issue),
    .rd_addr({iss_bank, iss_idx}),
    .rd_data(ram_rd_data)
  );

  always_comb begin
    out_valid_d = vld_p1_q;
    out_first_d = vld_p1_q & first_p1_q;
    out_last_d  = vld_p1_q & last_p1_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    if (vld_p1_q) begin
      out_r_d = ram_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
      out_i_d = ram_rd_data[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      drop_q      <= 1'b0;
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      last_p1_q   <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      // stage p1: RAM read data registered, markers follow alongside
      vld_p1_q    <= issue;
      first_p1_q  <= issue && (iss_idx == '0);
      last_p1_q   <= issue && (iss_idx == LAST_IDX);
      // stage p2: output register
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_r      = out_r_q;
  assign out_i      = out_i_q;
  assign out_valid  = out_valid_q;
  assign out_first  = out_first_q;
  assign out_last   = out_last_q;
  assign frame_drop = drop_q;

endmodule

// File: doc/fft_reorder_buffer.md
FFT_REORDER_BUFFER -- requirements
Module: fft_reorder_buffer

Interface
REQ-001 SHALL have parameter INTEGER_SIZE, default 4: integer bits of each signed fixed-point sample component.
REQ-002 SHALL have parameter FRACT_SIZE, default 14: fractional bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE.
REQ-003 SHALL have parameter NFFT, default 64: frame length, a power of two >= 4; ADDR_W = $clog2(NFFT).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_r/in_i hold a valid sample (driven by the FFT data_valid_FFT).
REQ-007 SHALL have port in_start, input, 1: marks the first sample of a frame, qualified by in_valid.
REQ-008 SHALL have ports in_r and in_i, input, signed DATA_WIDTH: FFT output, bit-reversed order.
REQ-009 SHALL have ports out_r and out_i, output, signed DATA_WIDTH: reordered samples, natural order.
REQ-010 SHALL have port out_valid, output, 1: out_r/out_i are valid this cycle.
REQ-011 SHALL have ports out_first and out_last, output, 1 each: high with bin 0 and bin NFFT-1, qualified by out_valid.
REQ-012 SHALL have port frame_drop, output, 1: one-cycle pulse when a partial frame is discarded.

Function
REQ-013 SHALL hold two banks of NFFT entries each, used ping-pong: one bank written while the other is read.
REQ-014 SHALL keep write counter wr_cnt (ADDR_W bits), advancing only on in_valid; each accepted sample is written to address bitrev(wr_cnt) of the write bank (NFFT=64: 1->32, 6->24, 63->63).
REQ-015 SHALL, on accepting sample NFFT-1, wrap wr_cnt to 0, mark the write bank full and toggle the write bank in the same edge.
REQ-016 SHALL, when in_valid and in_start are both high, write that sample at address 0 with wr_cnt=0 regardless of the prior count.
REQ-017 SHALL, if in_start arrives with wr_cnt != 0, discard the partial frame, leave the bank empty, not toggle, and pulse frame_drop.
REQ-018 SHALL implement the read FSM with states IDLE and READ.
REQ-019 SHALL move IDLE->READ when any bank is full; READ then reads addresses 0..NFFT-1 in order, one per cycle, with no gaps.
REQ-020 SHALL, after address NFFT-1, clear that bank's full flag; go to READ on the other bank on the next cycle if it is full, else to IDLE.
REQ-021 SHALL give latency: first out_valid of a frame 2 cycles after the edge that captures that frame's last input sample (sync RAM read plus output register).
REQ-022 SHALL sustain a continuous stream of back-to-back frames at one sample per clock with zero output gaps and no drops.
REQ-023 SHALL accept in_valid gaps at any point; gaps only delay frame completion.
REQ-024 SHALL pass data unchanged: no scaling, rounding or sign change.
REQ-025 SHALL resolve a same-cycle bank-full event and read-completion event by serving the newly full bank next; no cycle is lost.
REQ-026 SHALL hold out_r/out_i at their last value while out_valid is low.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, clear wr_cnt and both full flags, select bank 0 for writing, set the FSM to IDLE, and drive out_r/out_i to 0 with out_valid, out_first, out_last and frame_drop low.
REQ-028 SHALL abandon all buffered and partial frames on rst mid-operation; memory contents are not cleared and are never output before being rewritten.

Structure
REQ-029 SHALL take DATA_WIDTH, ADDR_W and the bit-reverse function from shared package fft_pkg.
REQ-030 SHALL place storage in one sub-module fft_reorder_ram: simple dual-port RAM, 2*NFFT x 2*DATA_WIDTH, one write and one registered read port, address = {bank, index}.

Verification
REQ-031 Ramp: one frame with in_r=j, in_i=-j for j=0..63 -> out_r sequence 0,32,16,48,8,40,... (bitrev(n)), out_first on the first sample, out_last on the 64th, first out_valid 2 cycles after the last input.
REQ-032 Streaming: 4 back-to-back frames with in_valid held high -> 256 consecutive out_valid cycles, every frame correctly reordered.
REQ-033 Gapped input: in_valid toggled 1,0 during a frame -> identical output data; output starts 2 cycles after the 64th accepted sample.
REQ-034 Restart: in_start at wr_cnt=20, then a full frame -> one frame_drop pulse; only the full frame is output.
REQ-035 Reset mid-read: rst for one cycle at output bin 10 -> out_valid low the next cycle with out_r=out_i=0; no stale data afterwards; a new frame reorders correctly.
REQ-036 Impulse: in_r=1.0 (0x04000) at input index 1, all others 0 -> out_r=0x04000 only at bin 32.
